// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the EHXPLLL phase-adjust port: turns fabric step
// requests into timed PHASESTEP pulses and tracks per-output phase offsets.
module pll_phase_ctrl #(
  parameter int SETUP_CYCLES = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int LOCK_CYCLES  = 16,
  parameter int STEP_WRAP    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [5:0]  req_count,
  output logic        done,
  output logic        err,
  output logic        lock_ok,
  output logic [23:0] pos,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg
);

  localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_C  = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LCK_W-1:0] LOCK_LAST  = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [5:0]       WRAP_MAX   = 6'(STEP_WRAP - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic [LCK_W-1:0] r_lock_cnt;
  logic [LCK_W-1:0] w_lock_cnt_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [5:0]       r_remaining;
  logic [3:0][5:0]  r_pos;
  logic [1:0]       r_phasesel;
  logic             r_phasedir;
  logic             r_phasestep;
  logic             r_req_ready;
  logic             r_lock_ok;
  logic             r_done;
  logic             r_err;
  logic             w_done_next;
  logic             w_err_next;
  logic             w_accept;
  logic             w_commit;

  // Delay moves forward, advance moves back; both wrap modulo STEP_WRAP.
  function automatic logic [5:0] pos_step(input logic [5:0] p, input logic dir);
    logic [5:0] r;
    if (dir == 1'b0) begin
      r = (p == WRAP_MAX) ? 6'd0 : p + 6'd1;
    end else begin
      r = (p == 6'd0) ? WRAP_MAX : p - 6'd1;
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_LOCK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and one-cycle event decode; lock loss in flight beats every other exit.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt + CNT_W'(1);
    w_lock_cnt_next = {LCK_W{1'b0}};
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    w_accept        = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_cnt_next = {CNT_W{1'b0}};
        if (r_sync2) begin
          if (r_lock_cnt == LOCK_LAST) begin
            w_state_next = ST_IDLE;
          end else begin
            w_lock_cnt_next = r_lock_cnt + LCK_W'(1);
          end
        end else begin
          w_lock_cnt_next = {LCK_W{1'b0}};
        end
      end
      ST_IDLE: begin
        w_cnt_next = {CNT_W{1'b0}};
        if (!r_sync2) begin
          w_state_next = ST_WAIT_LOCK;
        end else if (req_valid) begin
          w_accept = 1'b1;
          if (req_count == 6'd0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = ST_SETUP;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!r_sync2) begin
          w_state_next = ST_WAIT_LOCK;
          w_err_next   = 1'b1;
          w_cnt_next   = {CNT_W{1'b0}};
        end else if (r_cnt == SETUP_LAST) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = {CNT_W{1'b0}};
        end else begin
          w_state_next = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (!r_sync2) begin
          w_state_next = ST_WAIT_LOCK;
          w_err_next   = 1'b1;
          w_cnt_next   = {CNT_W{1'b0}};
        end else if (r_cnt == PULSE_LAST) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = {CNT_W{1'b0}};
          w_commit     = 1'b1;
        end else begin
          w_state_next = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (!r_sync2) begin
          w_state_next = ST_WAIT_LOCK;
          w_err_next   = 1'b1;
          w_cnt_next   = {CNT_W{1'b0}};
        end else if (r_cnt == HOLD_LAST) begin
          w_cnt_next = {CNT_W{1'b0}};
          if (r_remaining != 6'd0) begin
            w_state_next = ST_SETUP;
          end else begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      default: begin
        w_state_next = ST_WAIT_LOCK;
        w_cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Lock synchronizer, counters, position bookkeeping and registered PLL/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_lock_cnt  <= {LCK_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_remaining <= 6'd0;
      r_pos       <= {4{6'd0}};
      r_phasesel  <= 2'b00;
      r_phasedir  <= 1'b1;
      r_phasestep <= 1'b1;
      r_req_ready <= 1'b0;
      r_lock_ok   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync1     <= locked;
      r_sync2     <= r_sync1;
      r_lock_cnt  <= w_lock_cnt_next;
      r_cnt       <= w_cnt_next;
      r_phasestep <= (w_state_next != ST_PULSE);
      r_req_ready <= (w_state_next == ST_IDLE);
      r_lock_ok   <= (w_state_next != ST_WAIT_LOCK);
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      if (w_accept && (req_count != 6'd0)) begin
        r_remaining <= req_count;
        r_phasesel  <= req_sel;
        r_phasedir  <= req_dir;
      end else if (w_commit) begin
        r_remaining         <= r_remaining - 6'd1;
        r_pos[r_phasesel]   <= pos_step(r_pos[r_phasesel], r_phasedir);
      end else begin
        r_remaining <= r_remaining;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign done         = r_done;
  assign err          = r_err;
  assign lock_ok      = r_lock_ok;
  assign pos          = r_pos;
  assign phasesel     = r_phasesel;
  assign phasedir     = r_phasedir;
  assign phasestep    = r_phasestep;
  assign phaseloadreg = 1'b1;

endmodule
